// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-port memory
module mem_port_arbiter #(
  parameter int LAT = 1,
  parameter int RR  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_flush,
  output logic        o_if_done,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [2:0]  i_d_funct3,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_done,
  output logic        o_d_err,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_sp_addr,
  output logic        o_sp_re,
  output logic        o_sp_we,
  output logic [2:0]  o_sp_funct3,
  output logic [31:0] o_sp_wdata,
  input  logic [31:0] i_sp_rdata,
  output logic        o_stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic        r_is_d;
  logic        r_is_store;
  logic        r_last_d;
  logic        r_if_kill;
  logic        r_if_done;
  logic        w_if_req;
  logic        w_d_mis;
  logic        w_grant_d;
  logic        w_grant_if;
  logic        w_last;

  // A flush in the same cycle hides the fetch request from arbitration.
  assign w_if_req   = i_if_req & ~i_if_flush;
  assign w_d_mis    = ((i_d_funct3[1:0] == 2'b01) & i_d_addr[0]) |
                      ((i_d_funct3[1:0] == 2'b10) & (i_d_addr[1:0] != 2'b00));
  assign w_grant_d  = i_d_req & (~w_if_req | (RR == 0) | ~r_last_d);
  assign w_grant_if = w_if_req & ~w_grant_d;
  assign w_last     = (r_cnt == 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d)       w_next = w_d_mis ? RESP : ACCESS;
        else if (w_grant_if) w_next = ACCESS;
      end
      ACCESS: if (w_last) w_next = RESP;
      RESP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= 2'd0;
      r_is_d      <= 1'b0;
      r_is_store  <= 1'b0;
      r_last_d    <= 1'b1;
      r_if_kill   <= 1'b0;
      r_if_done   <= 1'b0;
      o_d_done    <= 1'b0;
      o_d_err     <= 1'b0;
      o_if_rdata  <= 32'd0;
      o_d_rdata   <= 32'd0;
      o_sp_addr   <= 32'd0;
      o_sp_re     <= 1'b0;
      o_sp_we     <= 1'b0;
      o_sp_funct3 <= 3'd0;
      o_sp_wdata  <= 32'd0;
    end else begin
      r_if_done <= 1'b0;
      o_d_done  <= 1'b0;
      o_d_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_is_d     <= 1'b1;
            r_last_d   <= 1'b1;
            r_is_store <= i_d_we;
            if (w_d_mis) begin
              o_d_done <= 1'b1;
              o_d_err  <= 1'b1;
            end else begin
              o_sp_addr   <= i_d_addr;
              o_sp_funct3 <= i_d_funct3;
              o_sp_wdata  <= i_d_wdata;
              o_sp_re     <= ~i_d_we;
              o_sp_we     <= i_d_we;
              r_cnt       <= 2'(LAT - 1);
            end
          end else if (w_grant_if) begin
            r_is_d      <= 1'b0;
            r_last_d    <= 1'b0;
            r_is_store  <= 1'b0;
            r_if_kill   <= 1'b0;
            o_sp_addr   <= i_if_addr & ~32'h3;
            o_sp_funct3 <= 3'b010;
            o_sp_re     <= 1'b1;
            o_sp_we     <= 1'b0;
            r_cnt       <= 2'(LAT - 1);
          end
        end
        ACCESS: begin
          o_sp_we <= 1'b0;
          if (!r_is_d && i_if_flush) r_if_kill <= 1'b1;
          if (!w_last) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            o_sp_re <= 1'b0;
            if (r_is_d) begin
              if (!r_is_store) o_d_rdata <= i_sp_rdata;
              o_d_done <= 1'b1;
            end else if (!(r_if_kill || i_if_flush)) begin
              o_if_rdata <= i_sp_rdata;
              r_if_done  <= 1'b1;
            end
          end
        end
        RESP: r_if_kill <= 1'b0;
        default: ;
      endcase
    end
  end

  // A flush arriving in the response cycle still swallows the done pulse.
  assign o_if_done = r_if_done & ~i_if_flush;
  assign o_stall   = (i_if_req & ~o_if_done) | (i_d_req & ~o_d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done, d_err;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] sp_addr, sp_wdata, sp_rdata;
  logic        sp_re, sp_we, stall;
  logic [2:0]  sp_funct3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:63];
  logic [63:0] mem_wr = '0;

  always #5 clk = ~clk;

  // Unwritten words read back as 0xA5000000 | word index.
  assign sp_rdata = mem_wr[sp_addr[7:2]] ? mem[sp_addr[7:2]] : (32'hA500_0000 | {26'd0, sp_addr[7:2]});

  always @(posedge clk) begin
    if (sp_we) begin
      mem[sp_addr[7:2]]    <= sp_wdata;
      mem_wr[sp_addr[7:2]] <= 1'b1;
    end
  end

  mem_port_arbiter #(.LAT(2), .RR(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_done(if_done), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_funct3(d_funct3), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .o_d_done(d_done), .o_d_err(d_err), .o_d_rdata(d_rdata),
    .o_sp_addr(sp_addr), .o_sp_re(sp_re), .o_sp_we(sp_we), .o_sp_funct3(sp_funct3),
    .o_sp_wdata(sp_wdata), .i_sp_rdata(sp_rdata), .o_stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b010; d_addr = '0; d_wdata = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic d_issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    do_reset();
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_d_done", {30'd0, d_done, d_err}, 32'd0);
    chk("rst_sp_ctl", {30'd0, sp_re, sp_we}, 32'd0);
    chk("rst_sp_addr", sp_addr, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);

    // fetch only, unaligned byte address
    if_req = 1'b1; if_addr = 32'h0000_0013;
    #1 chk("f_stall_c0", {31'd0, stall}, 32'd1);
    tick();
    chk("f_sp_addr_c1", sp_addr, 32'h10);
    chk("f_sp_ctl_c1", {28'd0, sp_funct3, sp_re}, {28'd0, 3'b010, 1'b1});
    chk("f_sp_we_c1", {31'd0, sp_we}, 32'd0);
    tick();
    chk("f_sp_re_c2", {31'd0, sp_re}, 32'd1);
    chk("f_done_c2", {31'd0, if_done}, 32'd0);
    tick();
    chk("f_done_c3", {31'd0, if_done}, 32'd1);
    chk("f_rdata_c3", if_rdata, 32'hA500_0004);
    chk("f_stall_c3", {31'd0, stall}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("f_done_c4", {31'd0, if_done}, 32'd0);

    // tie after reset: fetch first, then data
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    d_issue(1'b0, 3'b010, 32'h14, 32'd0);
    tick(); tick(); tick();
    chk("tie_if_done_c3", {30'd0, if_done, d_done}, 32'b10);
    if_req = 1'b0;
    tick();
    chk("tie_idle_c4", {30'd0, sp_re, d_done}, 32'd0);
    tick();
    chk("tie_d_addr_c5", sp_addr, 32'h14);
    tick();
    chk("tie_d_done_c6", {31'd0, d_done}, 32'd0);
    tick();
    chk("tie_d_done_c7", {29'd0, if_done, d_done, d_err}, 32'b010);
    chk("tie_d_rdata_c7", d_rdata, 32'hA500_0005);
    d_req = 1'b0;
    tick();

    // store then load back
    d_issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    tick();
    chk("st_we_c1", {30'd0, sp_we, sp_re}, 32'b10);
    chk("st_wdata_c1", sp_wdata, 32'hDEAD_BEEF);
    tick();
    chk("st_we_c2", {31'd0, sp_we}, 32'd0);
    tick();
    chk("st_done_c3", {30'd0, d_done, d_err}, 32'b10);
    d_issue(1'b0, 3'b010, 32'h20, 32'd0);
    tick();
    d_req = 1'b1;
    tick(); tick(); tick();
    chk("ld_done", {31'd0, d_done}, 32'd1);
    chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick();

    // misaligned word store and halfword load
    d_issue(1'b1, 3'b010, 32'h22, 32'h1234_5678);
    tick();
    chk("mis_w_c1", {28'd0, d_done, d_err, sp_we, sp_re}, 32'b1100);
    d_req = 1'b0;
    tick();
    d_issue(1'b0, 3'b001, 32'h21, 32'd0);
    tick();
    chk("mis_h_c1", {28'd0, d_done, d_err, sp_we, sp_re}, 32'b1100);
    d_req = 1'b0;
    tick();
    d_issue(1'b0, 3'b001, 32'h22, 32'd0);
    tick();
    chk("al_h_c1", {28'd0, d_done, d_err, sp_we, sp_re}, 32'b0001);
    tick(); tick();
    chk("al_h_c3", {30'd0, d_done, d_err}, 32'b10);
    d_req = 1'b0;
    tick();

    // flush in the last access cycle of a fetch
    if_req = 1'b1; if_addr = 32'h10;
    tick(); tick(); tick();
    chk("pre_flush_rdata", if_rdata, 32'hA500_0004);
    if_req = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h24;
    tick(); tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    chk("fl_done_c3", {31'd0, if_done}, 32'd0);
    chk("fl_rdata_c3", if_rdata, 32'hA500_0004);
    tick();
    d_issue(1'b0, 3'b010, 32'h14, 32'd0);
    tick(); tick();
    chk("fl_idle_d_c6", {31'd0, d_done}, 32'd0);
    tick();
    chk("fl_idle_d_c7", {31'd0, d_done}, 32'd1);
    d_req = 1'b0;
    tick();

    // flush in IDLE blocks the grant for that cycle only
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h24;
    tick();
    chk("fli_no_grant", {31'd0, sp_re}, 32'd0);
    if_flush = 1'b0;
    tick();
    chk("fli_grant", {31'd0, sp_re}, 32'd1);
    tick(); tick();
    chk("fli_done", {31'd0, if_done}, 32'd1);
    chk("fli_rdata", if_rdata, 32'hA500_0009);
    if_req = 1'b0;
    tick();

    // reset in the first access cycle of a store
    d_issue(1'b1, 3'b010, 32'h28, 32'h1234_5678);
    tick();
    chk("rs_we_c1", {31'd0, sp_we}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; d_req = 1'b0;
    chk("rs_ctl_c2", {27'd0, sp_we, sp_re, if_done, d_done, d_err}, 32'd0);
    chk("rs_addr_c2", sp_addr | sp_wdata, 32'd0);
    chk("rs_rdata_c2", if_rdata | d_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rs_no_done", {30'd0, d_done, sp_we}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
